// File: rtl/mips_isa_pkg.sv
// MIPS opcode/func constants, mnemonic codes and loader FSM states shared by
// the instruction encode loader and its bench.
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_LA    = 6'd6;
  localparam logic [5:0] OP_PTYPE = 6'd7;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_PADDI = 6'd9;
  localparam logic [5:0] OP_PBLT  = 6'd10;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_SLT = 6'd42;

  typedef enum logic [4:0] {
    MN_ADD   = 5'd0,
    MN_SUB   = 5'd1,
    MN_AND   = 5'd2,
    MN_OR    = 5'd3,
    MN_SLT   = 5'd4,
    MN_PADD  = 5'd5,
    MN_PSUB  = 5'd6,
    MN_PAND  = 5'd7,
    MN_POR   = 5'd8,
    MN_PSLT  = 5'd9,
    MN_ADDI  = 5'd10,
    MN_PADDI = 5'd11,
    MN_LW    = 5'd12,
    MN_SW    = 5'd13,
    MN_BEQ   = 5'd14,
    MN_BNE   = 5'd15,
    MN_PBLT  = 5'd16,
    MN_J     = 5'd17,
    MN_LA    = 5'd18
  } mnemonic_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic        legal;
    logic [31:0] word;
  } enc_result_t;

  function automatic logic [31:0] r_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [5:0] fn);
    return {op, rs, rt, rd, 5'b00000, fn};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_word(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

endpackage

// File: rtl/instr_encode_loader_if.sv
// Request and IMEM write-port bundle for the instruction encode loader; the
// loader takes the slave view, the boot loader / bench takes the master view.
interface instr_encode_loader_if #(
  parameter int ADDR_W = 8
);
  logic              load_start;
  logic              load_end;
  logic              enc_valid;
  logic              enc_ready;
  logic [4:0]        op_sel;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [15:0]       imm;
  logic [25:0]       target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              imem_ready;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   word_count;
  logic              illegal_err;
  logic              addr_wrap;

  modport master (
    output load_start, load_end, enc_valid, op_sel, rs, rt, rd, imm, target, imem_ready,
    input  enc_ready, imem_we, imem_addr, imem_wdata, busy, done, word_count,
           illegal_err, addr_wrap
  );

  modport slave (
    input  load_start, load_end, enc_valid, op_sel, rs, rt, rd, imm, target, imem_ready,
    output enc_ready, imem_we, imem_addr, imem_wdata, busy, done, word_count,
           illegal_err, addr_wrap
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-bit pointers; head word is visible
// combinationally on rdata_o whenever empty_o is low.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PTR_W = $clog2(DEPTH);
  typedef logic [PTR_W:0] ptr_t;

  logic [WIDTH-1:0] mem_q [DEPTH];
  ptr_t             wptr_q, wptr_d;
  ptr_t             rptr_q, rptr_d;
  logic             do_push, do_pop;

  assign full_o  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                   (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q[PTR_W-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + ptr_t'(1);
    if (do_pop)  rptr_d = rptr_q + ptr_t'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[PTR_W-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/instr_encode_loader.sv
// Encodes symbolic instruction requests into MIPS words, buffers them and
// streams them into IMEM at consecutive word addresses.
import mips_isa_pkg::*;

module instr_encode_loader #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int BASE_ADDR  = 0
) (
  input logic                 clk,
  input logic                 rst_n,
  instr_encode_loader_if.slave bus
);
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [ADDR_W:0]   cnt_t;

  state_e      state_q, state_d;
  enc_result_t enc;
  logic        enc_ready, done, busy;
  logic        accept, wr_fire, out_load;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [31:0] fifo_head;

  logic        imem_we_q, imem_we_d;
  addr_t       imem_addr_q, imem_addr_d;
  logic [31:0] imem_wdata_q, imem_wdata_d;
  cnt_t        count_q, count_d;
  logic        illegal_q, illegal_d;
  logic        wrap_q, wrap_d;

  function automatic enc_result_t encode(input logic [4:0] sel, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [15:0] imm, input logic [25:0] tgt);
    enc_result_t r;
    r.legal = 1'b1;
    r.word  = '0;
    case (sel)
      MN_ADD:   r.word = r_word(OP_RTYPE, rs, rt, rd, FN_ADD);
      MN_SUB:   r.word = r_word(OP_RTYPE, rs, rt, rd, FN_SUB);
      MN_AND:   r.word = r_word(OP_RTYPE, rs, rt, rd, FN_AND);
      MN_OR:    r.word = r_word(OP_RTYPE, rs, rt, rd, FN_OR);
      MN_SLT:   r.word = r_word(OP_RTYPE, rs, rt, rd, FN_SLT);
      MN_PADD:  r.word = r_word(OP_PTYPE, rs, rt, rd, FN_ADD);
      MN_PSUB:  r.word = r_word(OP_PTYPE, rs, rt, rd, FN_SUB);
      MN_PAND:  r.word = r_word(OP_PTYPE, rs, rt, rd, FN_AND);
      MN_POR:   r.word = r_word(OP_PTYPE, rs, rt, rd, FN_OR);
      MN_PSLT:  r.word = r_word(OP_PTYPE, rs, rt, rd, FN_SLT);
      MN_ADDI:  r.word = i_word(OP_ADDI, rs, rt, imm);
      MN_PADDI: r.word = i_word(OP_PADDI, rs, rt, imm);
      MN_LW:    r.word = i_word(OP_LW, rs, rt, imm);
      MN_SW:    r.word = i_word(OP_SW, rs, rt, imm);
      MN_BEQ:   r.word = i_word(OP_BEQ, rs, rt, imm);
      MN_BNE:   r.word = i_word(OP_BNE, rs, rt, imm);
      MN_PBLT:  r.word = i_word(OP_PBLT, rs, rt, imm);
      MN_J:     r.word = j_word(OP_J, tgt);
      MN_LA:    r.word = i_word(OP_LA, rs, rt, imm);
      default:  r.legal = 1'b0;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // load_start only matters in IDLE, and wins over a simultaneous load_end.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.load_start) state_d = ST_LOAD;
      ST_LOAD:  if (bus.load_end) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty && !imem_we_q) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    enc_ready = (state_q == ST_LOAD) && !fifo_full;
    done      = (state_q == ST_DRAIN) && fifo_empty && !imem_we_q;
    busy      = (state_q != ST_IDLE);
  end

  assign enc       = encode(bus.op_sel, bus.rs, bus.rt, bus.rd, bus.imm, bus.target);
  assign accept    = bus.enc_valid && enc_ready;
  assign fifo_push = accept && enc.legal;
  assign wr_fire   = imem_we_q && bus.imem_ready;
  assign out_load  = !imem_we_q || bus.imem_ready;
  assign fifo_pop  = out_load && !fifo_empty;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .wdata_i (enc.word),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // imem_addr always names the slot of the word currently presented, so it
  // advances only when that word is taken by the memory.
  always_comb begin
    imem_we_d    = imem_we_q;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    count_d      = count_q;
    illegal_d    = illegal_q;
    wrap_d       = wrap_q;
    if (out_load) begin
      imem_we_d = !fifo_empty;
      if (!fifo_empty) imem_wdata_d = fifo_head;
    end
    if (wr_fire) begin
      imem_addr_d = imem_addr_q + addr_t'(1);
      count_d     = count_q + cnt_t'(1);
      if (imem_addr_q == '1) wrap_d = 1'b1;
    end
    if (accept && !enc.legal) illegal_d = 1'b1;
    if ((state_q == ST_IDLE) && bus.load_start) begin
      imem_addr_d = addr_t'(BASE_ADDR);
      count_d     = '0;
      illegal_d   = 1'b0;
      wrap_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      count_q      <= '0;
      illegal_q    <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      count_q      <= count_d;
      illegal_q    <= illegal_d;
      wrap_q       <= wrap_d;
    end
  end

  assign bus.enc_ready   = enc_ready;
  assign bus.imem_we     = imem_we_q;
  assign bus.imem_addr   = imem_addr_q;
  assign bus.imem_wdata  = imem_wdata_q;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.word_count  = count_q;
  assign bus.illegal_err = illegal_q;
  assign bus.addr_wrap   = wrap_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader: a default instance (ADDR_W=8,
// BASE_ADDR=0) and a small wrapping instance (ADDR_W=2, BASE_ADDR=3).
module tb_instr_encode_loader;
  import mips_isa_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_encode_loader_if #(.ADDR_W(8)) busA ();
  instr_encode_loader_if #(.ADDR_W(2)) busB ();

  instr_encode_loader #(.ADDR_W(8), .FIFO_DEPTH(4), .BASE_ADDR(0)) dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busA)
  );

  instr_encode_loader #(.ADDR_W(2), .FIFO_DEPTH(4), .BASE_ADDR(3)) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busB)
  );

  int errors = 0;
  int checks = 0;
  int doneA = 0;
  int doneB = 0;
  logic [7:0]  logAddr[$];
  logic [31:0] logData[$];
  logic [1:0]  logAddrB[$];
  logic [31:0] logDataB[$];
  logic        stallPrev = 1'b0;
  logic [7:0]  stallAddr = '0;
  logic [31:0] stallData = '0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Write log, done-pulse count and hold-under-stall check, all sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stallPrev) begin
        checkOutput("stall_we", 32'(busA.imem_we), 32'd1);
        checkOutput("stall_addr", 32'(busA.imem_addr), 32'(stallAddr));
        checkOutput("stall_data", busA.imem_wdata, stallData);
      end
      if (busA.imem_we && busA.imem_ready) begin
        logAddr.push_back(busA.imem_addr);
        logData.push_back(busA.imem_wdata);
      end
      if (busB.imem_we && busB.imem_ready) begin
        logAddrB.push_back(busB.imem_addr);
        logDataB.push_back(busB.imem_wdata);
      end
      if (busA.done) doneA++;
      if (busB.done) doneB++;
    end
    stallPrev = rst_n && busA.imem_we && !busA.imem_ready;
    stallAddr = busA.imem_addr;
    stallData = busA.imem_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic startSession();
    logAddr.delete();
    logData.delete();
    doneA = 0;
    busA.load_start = 1'b1;
    tick();
    busA.load_start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
    bit accepted = 1'b0;
    busA.enc_valid = 1'b1;
    busA.op_sel = op;
    busA.rs = rs;
    busA.rt = rt;
    busA.rd = rd;
    busA.imm = imm;
    busA.target = tgt;
    for (int i = 0; i < 100 && !accepted; i++) begin
      @(negedge clk);
      if (busA.enc_ready) accepted = 1'b1;
      tick();
    end
    busA.enc_valid = 1'b0;
    checkOutput("accept", 32'(accepted), 32'd1);
  endtask

  task automatic finishSession(input int expWords);
    busA.load_end = 1'b1;
    tick();
    busA.load_end = 1'b0;
    for (int i = 0; i < 100 && doneA == 0; i++) tick();
    repeat (3) tick();
    checkOutput("done_pulses", 32'(doneA), 32'd1);
    checkOutput("busy_after", 32'(busA.busy), 32'd0);
    checkOutput("word_count", 32'(busA.word_count), 32'(expWords));
    checkOutput("log_size", 32'(logAddr.size()), 32'(expWords));
  endtask

  task automatic expectWrite(input string tag, input int idx, input logic [7:0] addr,
                             input logic [31:0] data);
    checkOutput({tag, "_addr"}, (idx < logAddr.size()) ? 32'(logAddr[idx]) : 32'hDEADBEEF, 32'(addr));
    checkOutput({tag, "_data"}, (idx < logData.size()) ? logData[idx] : 32'hDEADBEEF, data);
  endtask

  initial begin
    int k;
    bit acc;
    busA.load_start = 0; busA.load_end = 0; busA.enc_valid = 0; busA.imem_ready = 1;
    busA.op_sel = 0; busA.rs = 0; busA.rt = 0; busA.rd = 0; busA.imm = 0; busA.target = 0;
    busB.load_start = 0; busB.load_end = 0; busB.enc_valid = 0; busB.imem_ready = 1;
    busB.op_sel = 0; busB.rs = 0; busB.rt = 0; busB.rd = 0; busB.imm = 0; busB.target = 0;

    #2;
    checkOutput("rst_busy", 32'(busA.busy), 32'd0);
    checkOutput("rst_we", 32'(busA.imem_we), 32'd0);
    checkOutput("rst_ready", 32'(busA.enc_ready), 32'd0);
    checkOutput("rst_addr", 32'(busA.imem_addr), 32'd0);
    checkOutput("rst_wdata", busA.imem_wdata, 32'd0);
    checkOutput("rst_count", 32'(busA.word_count), 32'd0);
    checkOutput("rst_done", 32'(busA.done), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    checkOutput("idle_ready", 32'(busA.enc_ready), 32'd0);

    $display("[TB] basic R-type and latency");
    startSession();
    busA.enc_valid = 1; busA.op_sel = MN_ADD; busA.rs = 1; busA.rt = 2; busA.rd = 3;
    @(negedge clk);
    checkOutput("basic_ready", 32'(busA.enc_ready), 32'd1);
    tick();
    busA.enc_valid = 0;
    @(negedge clk);
    checkOutput("lat_cycle1_we", 32'(busA.imem_we), 32'd0);
    @(negedge clk);
    checkOutput("lat_cycle2_we", 32'(busA.imem_we), 32'd1);
    checkOutput("lat_cycle2_addr", 32'(busA.imem_addr), 32'd0);
    checkOutput("lat_cycle2_data", busA.imem_wdata, 32'h00221820);
    finishSession(1);

    $display("[TB] mixed formats, start+end together");
    logAddr.delete(); logData.delete(); doneA = 0;
    busA.load_start = 1; busA.load_end = 1;
    tick();
    busA.load_start = 0; busA.load_end = 0;
    tick();
    checkOutput("startend_busy", 32'(busA.busy), 32'd1);
    checkOutput("startend_ready", 32'(busA.enc_ready), 32'd1);
    applyStimulus(MN_ADDI, 0, 4, 0, 16'hFFFF, 0);
    applyStimulus(MN_LW, 4, 5, 0, 16'h0008, 0);
    applyStimulus(MN_J, 0, 0, 0, 0, 26'h10);
    applyStimulus(MN_PSUB, 1, 2, 3, 0, 0);
    applyStimulus(MN_SW, 29, 31, 0, 16'h0004, 0);
    applyStimulus(MN_BEQ, 1, 2, 0, 16'hFFFE, 0);
    finishSession(6);
    expectWrite("addi", 0, 8'd0, 32'h2004FFFF);
    expectWrite("lw", 1, 8'd1, 32'h8C850008);
    expectWrite("j", 2, 8'd2, 32'h08000010);
    expectWrite("psub", 3, 8'd3, 32'h1C221822);
    expectWrite("sw", 4, 8'd4, 32'hAFBF0004);
    expectWrite("beq", 5, 8'd5, 32'h1022FFFE);
    checkOutput("mixed_illegal", 32'(busA.illegal_err), 32'd0);
    checkOutput("mixed_wrap", 32'(busA.addr_wrap), 32'd0);

    $display("[TB] backpressure");
    startSession();
    busA.imem_ready = 0;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      busA.enc_valid = (k < 6);
      busA.op_sel = MN_ADDI; busA.rs = 0; busA.rt = 1; busA.imm = 16'(k);
      @(negedge clk);
      acc = busA.enc_valid && busA.enc_ready;
      tick();
      if (acc) k++;
    end
    checkOutput("bp_accepted", 32'(k), 32'd5);
    checkOutput("bp_ready_low", 32'(busA.enc_ready), 32'd0);
    checkOutput("bp_we", 32'(busA.imem_we), 32'd1);
    checkOutput("bp_addr", 32'(busA.imem_addr), 32'd0);
    checkOutput("bp_data", busA.imem_wdata, 32'h20010000);
    checkOutput("bp_no_writes", 32'(logAddr.size()), 32'd0);
    busA.imem_ready = 1;
    for (int c = 0; c < 50 && k < 6; c++) begin
      busA.enc_valid = 1; busA.imm = 16'(k);
      @(negedge clk);
      acc = busA.enc_ready;
      tick();
      if (acc) k++;
    end
    busA.enc_valid = 0;
    checkOutput("bp_all_accepted", 32'(k), 32'd6);
    finishSession(6);
    for (int i = 0; i < 6; i++) expectWrite("bp", i, 8'(i), 32'h20010000 | 32'(i));

    $display("[TB] illegal op_sel");
    startSession();
    applyStimulus(MN_ADD, 1, 2, 3, 0, 0);
    applyStimulus(5'd25, 7, 7, 7, 16'h1234, 0);
    checkOutput("ill_ready_kept", 32'(busA.enc_ready), 32'd1);
    applyStimulus(MN_ADD, 4, 5, 6, 0, 0);
    finishSession(2);
    checkOutput("ill_err", 32'(busA.illegal_err), 32'd1);
    expectWrite("ill0", 0, 8'd0, 32'h00221820);
    expectWrite("ill1", 1, 8'd1, 32'h00853020);

    $display("[TB] reset mid-load");
    startSession();
    checkOutput("ill_cleared", 32'(busA.illegal_err), 32'd0);
    checkOutput("count_cleared", 32'(busA.word_count), 32'd0);
    busA.imem_ready = 0;
    applyStimulus(MN_ADDI, 0, 1, 0, 16'h0001, 0);
    applyStimulus(MN_ADDI, 0, 1, 0, 16'h0002, 0);
    applyStimulus(MN_ADDI, 0, 1, 0, 16'h0003, 0);
    checkOutput("pre_rst_we", 32'(busA.imem_we), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", 32'(busA.busy), 32'd0);
    checkOutput("mid_rst_we", 32'(busA.imem_we), 32'd0);
    checkOutput("mid_rst_ready", 32'(busA.enc_ready), 32'd0);
    checkOutput("mid_rst_addr", 32'(busA.imem_addr), 32'd0);
    checkOutput("mid_rst_wdata", busA.imem_wdata, 32'd0);
    tick();
    checkOutput("post_rst_busy", 32'(busA.busy), 32'd0);
    checkOutput("post_rst_we", 32'(busA.imem_we), 32'd0);
    rst_n = 1'b1;
    busA.imem_ready = 1;
    tick();
    startSession();
    applyStimulus(MN_ADD, 1, 2, 3, 0, 0);
    finishSession(1);
    expectWrite("restart", 0, 8'd0, 32'h00221820);

    $display("[TB] address wrap");
    busB.load_start = 1;
    tick();
    busB.load_start = 0;
    checkOutput("wrap_base", 32'(busB.imem_addr), 32'd3);
    busB.enc_valid = 1; busB.op_sel = MN_ADD; busB.rs = 1; busB.rt = 2; busB.rd = 3;
    @(negedge clk);
    checkOutput("wrap_ready0", 32'(busB.enc_ready), 32'd1);
    tick();
    busB.op_sel = MN_SUB;
    @(negedge clk);
    checkOutput("wrap_ready1", 32'(busB.enc_ready), 32'd1);
    tick();
    busB.enc_valid = 0;
    busB.load_end = 1;
    tick();
    busB.load_end = 0;
    repeat (8) tick();
    checkOutput("wrap_writes", 32'(logAddrB.size()), 32'd2);
    checkOutput("wrap_w0_addr", (logAddrB.size() > 0) ? 32'(logAddrB[0]) : 32'hDEADBEEF, 32'd3);
    checkOutput("wrap_w0_data", (logDataB.size() > 0) ? logDataB[0] : 32'hDEADBEEF, 32'h00221820);
    checkOutput("wrap_w1_addr", (logAddrB.size() > 1) ? 32'(logAddrB[1]) : 32'hDEADBEEF, 32'd0);
    checkOutput("wrap_w1_data", (logDataB.size() > 1) ? logDataB[1] : 32'hDEADBEEF, 32'h00221822);
    checkOutput("wrap_flag", 32'(busB.addr_wrap), 32'd1);
    checkOutput("wrap_count", 32'(busB.word_count), 32'd2);
    checkOutput("wrap_done", 32'(doneB), 32'd1);
    checkOutput("wrap_busy", 32'(busB.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
